// File: rtl/lcd_axil_pkg.sv
// Shared types and response codes for the LCD AXI4-Lite register bank.
package lcd_axil_pkg;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    localparam axi_resp_t RESP_OKAY   = AXI_OKAY;
    localparam axi_resp_t RESP_SLVERR = AXI_SLVERR;

endpackage

// File: rtl/lcd_axil_byte_merge.sv
// Byte-lane merge: each strobe bit selects the new byte over the old one.
module lcd_axil_byte_merge
    import lcd_axil_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged_word
);

    // Per-lane select between stored and incoming byte.
    always_comb begin
        merged_word = old_word;
        for (int b = 0; b < DATA_W / 8; b++) begin
            merged_word[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
    end

endmodule

// File: rtl/lcd_axil_regfile.sv
// Parametrised AXI4-Lite register bank for the LCD core with RO status slots and write pulses.
// Optional macro LCD_AXIL_REGFILE_SLVERR_EN: out-of-range and read-only accesses answer SLVERR.
module lcd_axil_regfile
    import lcd_axil_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 8,
    parameter int                  ADDR_W   = $clog2(NUM_REGS) + 2,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [DATA_W-1:0]          S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic [1:0]                 S_AXI_BRESP,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [DATA_W-1:0]          S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    input  logic [NUM_REGS*DATA_W-1:0] stat_in,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    localparam int LSB    = $clog2(DATA_W / 8);
    localparam int STRB_W = DATA_W / 8;

    wr_state_t                       wr_state_q, wr_state_d;
    logic                            aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0]               aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]               wdata_q, wdata_d;
    logic [STRB_W-1:0]               wstrb_q, wstrb_d;
    logic                            awready_q, awready_d, wready_q, wready_d;
    logic                            bvalid_q, bvalid_d;
    axi_resp_t                       bresp_q, bresp_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             wr_pulse_q, wr_pulse_d;
    rd_state_t                       rd_state_q, rd_state_d;
    logic                            arready_q, arready_d, rvalid_q, rvalid_d;
    axi_resp_t                       rresp_q, rresp_d;
    logic [DATA_W-1:0]               rdata_q, rdata_d;

    logic [ADDR_W-1:0]   ar_idx_s;
    logic [NUM_REGS-1:0] wr_hit_s, rd_hit_s;
    logic                wr_in_range_s, wr_ro_s, wr_rw_s, wr_err_s, rd_in_range_s, rd_err_s;
    logic [DATA_W-1:0]   wr_old_s, wr_merged_s, rd_word_s;

    assign ar_idx_s      = S_AXI_ARADDR >> LSB;
    assign wr_in_range_s = |wr_hit_s;
    assign wr_ro_s       = |(wr_hit_s & RO_MASK);
    assign wr_rw_s       = wr_in_range_s && !wr_ro_s;
    assign rd_in_range_s = |rd_hit_s;

`ifdef LCD_AXIL_REGFILE_SLVERR_EN
    assign wr_err_s = !wr_rw_s;
    assign rd_err_s = !rd_in_range_s;
`else
    assign wr_err_s = 1'b0;
    assign rd_err_s = 1'b0;
`endif

    // Slot decode for the latched write index and the live read address.
    always_comb begin
        wr_hit_s  = {NUM_REGS{1'b0}};
        rd_hit_s  = {NUM_REGS{1'b0}};
        wr_old_s  = {DATA_W{1'b0}};
        rd_word_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit_s[i] = (aw_idx_q == ADDR_W'(i));
            rd_hit_s[i] = (ar_idx_s == ADDR_W'(i));
            wr_old_s    = wr_old_s | (wr_hit_s[i] ? regs_q[i] : {DATA_W{1'b0}});
            rd_word_s   = rd_word_s | (rd_hit_s[i] ?
                          (RO_MASK[i] ? stat_in[i*DATA_W +: DATA_W] : regs_q[i]) : {DATA_W{1'b0}});
        end
    end

    lcd_axil_byte_merge #(
        .DATA_W (DATA_W)
    ) u_byte_merge (
        .old_word    (wr_old_s),
        .new_word    (wdata_q),
        .strb        (wstrb_q),
        .merged_word (wr_merged_s)
    );

    // Write channel: AW and W latch independently; commit once both are held.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = {NUM_REGS{1'b0}};
        case (wr_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        regs_d[i]     = (wr_rw_s && wr_hit_s[i]) ? wr_merged_s : regs_q[i];
                        wr_pulse_d[i] = wr_rw_s && wr_hit_s[i];
                    end
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_err_s ? RESP_SLVERR : RESP_OKAY;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_RESP;
                end else begin
                    if (S_AXI_AWVALID && awready_q) begin
                        aw_held_d = 1'b1;
                        aw_idx_d  = S_AXI_AWADDR >> LSB;
                    end else begin
                        aw_held_d = aw_held_q;
                    end
                    if (S_AXI_WVALID && wready_q) begin
                        w_held_d = 1'b1;
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
                    end else begin
                        w_held_d = w_held_q;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                bvalid_d   = 1'b0;
            end
        endcase
        awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
    end

    // Read channel: one-deep, data captured on the address handshake.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    rdata_d    = rd_in_range_s ? rd_word_s : {DATA_W{1'b0}};
                    rresp_d    = rd_err_s ? RESP_SLVERR : RESP_OKAY;
                    rvalid_d   = 1'b1;
                    rd_state_d = R_DATA;
                end else begin
                    rvalid_d = 1'b0;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                rvalid_d   = 1'b0;
            end
        endcase
        arready_d = (rd_state_d == R_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            wstrb_q    <= {STRB_W{1'b0}};
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            regs_q     <= {(NUM_REGS*DATA_W){1'b0}};
            wr_pulse_q <= {NUM_REGS{1'b0}};
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= {DATA_W{1'b0}};
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_out       = regs_q;
    assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_lcd_axil_regfile.sv
// Randomised self-checking bench for lcd_axil_regfile (8 slots, slot 7 read-only, 6-bit address).
module tb_lcd_axil_regfile;

    localparam logic [7:0] RO_C = 8'h80;
`ifdef LCD_AXIL_REGFILE_SLVERR_EN
    localparam bit SLV_C = 1'b1;
`else
    localparam bit SLV_C = 1'b0;
`endif

    logic         ACLK, ARESET;
    logic [5:0]   S_AXI_AWADDR, S_AXI_ARADDR;
    logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
    logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic         S_AXI_RVALID, S_AXI_RREADY;
    logic [255:0] reg_out, stat_in;
    logic [7:0]   wr_pulse;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [8];
    logic [31:0] stat_mem [8];
    int          exp_cnt [8];
    int          pulse_cnt [8];

    lcd_axil_regfile #(
        .DATA_W (32), .NUM_REGS (8), .ADDR_W (6), .RO_MASK (RO_C)
    ) dut (
        .ACLK (ACLK), .ARESET (ARESET),
        .S_AXI_AWADDR (S_AXI_AWADDR), .S_AXI_AWVALID (S_AXI_AWVALID), .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA (S_AXI_WDATA), .S_AXI_WSTRB (S_AXI_WSTRB), .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY), .S_AXI_BRESP (S_AXI_BRESP), .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY), .S_AXI_ARADDR (S_AXI_ARADDR), .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY), .S_AXI_RDATA (S_AXI_RDATA), .S_AXI_RRESP (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID), .S_AXI_RREADY (S_AXI_RREADY),
        .reg_out (reg_out), .stat_in (stat_in), .wr_pulse (wr_pulse)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Count high cycles of each write pulse.
    always @(negedge ACLK) begin
        for (int i = 0; i < 8; i++) pulse_cnt[i] <= pulse_cnt[i] + int'(wr_pulse[i]);
    end

    task automatic chk_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [5:0] addr);
        int idx = int'(addr[5:2]);
        if (idx >= 8) return 32'h0;
        if (RO_C[idx]) return stat_mem[idx];
        return model[idx];
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [5:0] addr);
        return (SLV_C && addr[5:2] >= 4'd8) ? 2'b10 : 2'b00;
    endfunction

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int idx, cyc;
        bit rw_hit, aw_done, w_done, aw_hs, w_hs;
        logic [7:0] exp_pulse;
        logic [1:0] exp_resp;
        idx    = int'(addr[5:2]);
        rw_hit = 1'b0;
        if (idx < 8) rw_hit = !RO_C[idx];
        exp_pulse = rw_hit ? (8'h01 << idx) : 8'h00;
        exp_resp  = (SLV_C && !rw_hit) ? 2'b10 : 2'b00;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 64) begin
            @(negedge ACLK);
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            #1;
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK);
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
        end
        chk_val("aw_w_accept", {aw_done, w_done}, 2'b11);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk_val("bvalid_before_commit", S_AXI_BVALID, 1'b0);
        @(negedge ACLK);
        if (rw_hit) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            exp_cnt[idx]++;
        end
        chk_val("bvalid_commit", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, exp_resp});
        chk_val("wr_pulse_commit", wr_pulse, exp_pulse);
        chk_val("reg_out", reg_out, exp_flat());
        for (int c = 0; c < b_dly; c++) begin
            @(negedge ACLK);
            chk_val("bvalid_hold", {S_AXI_BVALID, S_AXI_BRESP, wr_pulse}, {1'b1, exp_resp, 8'h00});
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        chk_val("b_done", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, wr_pulse}, {3'b011, 8'h00});
    endtask

    task automatic axi_read(input logic [5:0] addr, input int ar_dly, input int r_dly,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit done;
        int cyc;
        repeat (ar_dly) @(negedge ACLK);
        S_AXI_ARADDR = addr;
        done = 1'b0; cyc = 0;
        while (!done && cyc < 64) begin
            @(negedge ACLK);
            S_AXI_ARVALID = 1'b1;
            #1;
            done = S_AXI_ARREADY;
            @(posedge ACLK);
            cyc++;
        end
        chk_val("ar_accept", done, 1'b1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        chk_val($sformatf("rd_%0h", addr), {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, exp_resp, exp_data});
        for (int c = 0; c < r_dly; c++) begin
            @(negedge ACLK);
            chk_val("rvalid_hold", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, exp_resp, exp_data});
        end
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        chk_val("r_done", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);
    endtask

    task automatic rd_model(input logic [5:0] addr, input int ar_dly, input int r_dly);
        axi_read(addr, ar_dly, r_dly, exp_rdata(addr), exp_rresp(addr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0]  a;
        logic [31:0] old_v;
        ARESET = 1'b1;
        S_AXI_AWADDR = 6'h0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = 6'h0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            model[i]     = 32'h0;
            exp_cnt[i]   = 0;
            pulse_cnt[i] = 0;
            stat_mem[i]  = (i == 7) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i);
            stat_in[i*32 +: 32] = stat_mem[i];
        end

        // Reset state and ready release.
        repeat (3) @(negedge ACLK);
        chk_val("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        chk_val("rst_valid", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}, 6'h00);
        chk_val("rst_rdata", S_AXI_RDATA, 32'h0);
        chk_val("rst_regs", {wr_pulse, reg_out}, 264'h0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk_val("ready_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Walk.
        for (int i = 0; i < 8; i++) axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 8; i++) rd_model(6'(i * 4), 0, 0);

        // Strobe merge.
        axi_write(6'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        axi_write(6'h00, 32'h11223344, 4'b0101, 0, 0, 0);
        axi_read(6'h00, 0, 1, 32'hAA22CC44, 2'b00);

        // Independent AW/W ordering with a stalled response.
        axi_write(6'h04, 32'h0A0B0C0D, 4'hF, 0, 3, 5);
        axi_write(6'h08, 32'h01020304, 4'hF, 3, 0, 5);
        rd_model(6'h04, 0, 0);
        rd_model(6'h08, 0, 0);

        // Read-only slot.
        axi_write(6'h1C, 32'h0, 4'hF, 0, 0, 0);
        axi_read(6'h1C, 0, 0, 32'hDEADBEEF, 2'b00);
        chk_val("ro_no_pulse", pulse_cnt[7], 0);

        // Out-of-range write and read.
        axi_write(6'h20, 32'h55, 4'hF, 0, 0, 0);
        axi_read(6'h20, 0, 0, 32'h0, SLV_C ? 2'b10 : 2'b00);

        // Read and commit on the same edge see the old value.
        old_v = model[3];
        fork
            axi_write(6'h0C, 32'hFEEDF00D, 4'hF, 0, 0, 0);
            axi_read(6'h0C, 1, 0, old_v, 2'b00);
        join
        rd_model(6'h0C, 0, 0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            a = 6'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            else
                rd_model(a, 0, $urandom_range(0, 2));
        end

        // Reset while a write response and read data are pending.
        @(negedge ACLK);
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        exp_cnt[0]++;
        chk_val("pre_rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        #2 ARESET = 1'b1;
        #1;
        chk_val("async_rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        chk_val("async_rst_regs", reg_out, 256'h0);
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        @(negedge ACLK);
        chk_val("rst_ready_low", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk_val("ready_after_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        rd_model(6'h00, 0, 0);
        axi_write(6'h10, 32'h00C0FFEE, 4'b0011, 1, 0, 1);
        rd_model(6'h10, 0, 0);

        repeat (2) @(negedge ACLK);
        for (int i = 0; i < 8; i++) chk_val($sformatf("pulse_cnt%0d", i), pulse_cnt[i], exp_cnt[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
